// File: rtl/my_led_axil.sv
// AXI4-Lite slave with four 32-bit registers; the low byte of register 0 drives the LEDs.
// Define MY_LED_INVERT_EN to drive led active-low (led = ~reg0[7:0]); readback is unaffected.
module my_led_axil #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [3:0]                      s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [7:0]                      led
);

    localparam int NUM_REGS = 4;

    logic                          awready_q, awready_d;
    logic                          wready_q,  wready_d;
    logic                          bvalid_q,  bvalid_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q,  rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic       wr_fire;
    logic       rd_fire;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;

    // Protection bits and the non-decoded address bits are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    assign wr_sel  = s_axi_awaddr[3:2];
    assign rd_sel  = s_axi_araddr[3:2];
    assign wr_fire = awready_q & s_axi_awvalid & wready_q & s_axi_wvalid;
    assign rd_fire = arready_q & s_axi_arvalid;

    // Byte-lane register update, applied on the edge where the write handshake completes.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            for (genvar bi = 0; bi < 4; bi++) begin : g_byte
                assign regs_d[gi][8*bi +: 8] =
                    (wr_fire && (wr_sel == 2'(gi)) && s_axi_wstrb[bi])
                        ? s_axi_wdata[8*bi +: 8]
                        : regs_q[gi][8*bi +: 8];
            end
        end
    endgenerate

    // Write channel: accept address and data together, one pulse, only with no response pending.
    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q;
        if (s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q) begin
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end
    end

    // Read channel: data is sampled at the handshake edge, so a simultaneous write is not seen.
    always_comb begin
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (s_axi_arvalid && !rvalid_q && !arready_q) begin
            arready_d = 1'b1;
        end
        if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[rd_sel];
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;

`ifdef MY_LED_INVERT_EN
    assign led = ~regs_q[0][7:0];
`else
    assign led = regs_q[0][7:0];
`endif

endmodule

// File: tb/tb_my_led_axil.sv
// Self-checking bench for my_led_axil: table of directed transactions plus handshake corner sequences.
module tb_my_led_axil;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    my_led_axil #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .led(led)
    );

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    function automatic logic [7:0] led_of(input logic [7:0] r);
`ifdef MY_LED_INVERT_EN
        return ~r;
`else
        return r;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake t=%0t", name, $time);
    endtask

    task automatic wait_sig(input string name, input int which, output bit got);
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if ((which == 0 && awready) || (which == 1 && arready)) begin
                got = 1;
                break;
            end
        end
        if (!got) timeout_fail(name);
    endtask

    task automatic add_vec(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_rdata, input logic [7:0] exp_led);
        vecs[nvec].is_wr     = is_wr;
        vecs[nvec].addr      = addr;
        vecs[nvec].data      = data;
        vecs[nvec].strb      = strb;
        vecs[nvec].exp_rdata = exp_rdata;
        vecs[nvec].exp_led   = exp_led;
        nvec++;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [7:0] exp_led);
        bit got;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        wait_sig("wr_awready", 0, got);
        if (got) begin
            chk("wr_wready_with_awready", {31'd0, wready}, 32'd1);
            @(posedge clk); #1;
            awvalid = 1'b0; wvalid = 1'b0;
            chk("wr_awready_one_cycle", {31'd0, awready}, 32'd0);
            chk("wr_wready_one_cycle", {31'd0, wready}, 32'd0);
            chk("wr_bvalid", {31'd0, bvalid}, 32'd1);
            chk("wr_bresp", {30'd0, bresp}, 32'd0);
            chk("wr_led", {24'd0, led}, {24'd0, exp_led});
            @(posedge clk); #1;
            chk("wr_bvalid_clear", {31'd0, bvalid}, 32'd0);
        end
        $display("WRITE addr=%h data=%h strb=%h led=%h", addr, data, strb, led);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input logic [7:0] exp_led);
        bit got;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        wait_sig("rd_arready", 1, got);
        if (got) begin
            @(posedge clk); #1;
            arvalid = 1'b0;
            chk("rd_arready_one_cycle", {31'd0, arready}, 32'd0);
            chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
            chk("rd_rdata", rdata, exp);
            chk("rd_rresp", {30'd0, rresp}, 32'd0);
            chk("rd_led", {24'd0, led}, {24'd0, exp_led});
            @(posedge clk); #1;
            chk("rd_rvalid_clear", {31'd0, rvalid}, 32'd0);
        end
        $display("READ  addr=%h rdata=%h exp=%h", addr, rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;

        // Table: reset readback, LED walk, partial strobe, scratch registers, aliasing, zero strobe.
        for (int i = 0; i < 4; i++) add_vec(1'b0, 32'(i * 4), 32'd0, 4'h0, 32'd0, led_of(8'h00));
        for (int i = 0; i < 16; i++) add_vec(1'b1, 32'h0, 32'(i), 4'hF, 32'd0, led_of(8'(i)));
        add_vec(1'b1, 32'h0,  32'h0000AB00, 4'b0010, 32'd0,        led_of(8'h0F));
        add_vec(1'b0, 32'h0,  32'd0,        4'h0,    32'h0000AB0F, led_of(8'h0F));
        add_vec(1'b1, 32'h4,  32'hDEADBEEF, 4'hF,    32'd0,        led_of(8'h0F));
        add_vec(1'b1, 32'hC,  32'h12345678, 4'hF,    32'd0,        led_of(8'h0F));
        add_vec(1'b0, 32'h4,  32'd0,        4'h0,    32'hDEADBEEF, led_of(8'h0F));
        add_vec(1'b0, 32'hC,  32'd0,        4'h0,    32'h12345678, led_of(8'h0F));
        add_vec(1'b0, 32'h14, 32'd0,        4'h0,    32'hDEADBEEF, led_of(8'h0F));
        add_vec(1'b1, 32'h8,  32'h00000055, 4'h0,    32'd0,        led_of(8'h0F));
        add_vec(1'b0, 32'h9,  32'd0,        4'h0,    32'h00000000, led_of(8'h0F));
        add_vec(1'b1, 32'h1,  32'h11223344, 4'b1100, 32'd0,        led_of(8'h0F));
        add_vec(1'b0, 32'h0,  32'd0,        4'h0,    32'h1122AB0F, led_of(8'h0F));

        #10;
        chk("reset_led", {24'd0, led}, {24'd0, led_of(8'h00)});
        chk("reset_bvalid", {31'd0, bvalid}, 32'd0);
        #10;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_led", {24'd0, led}, {24'd0, led_of(8'h00)});
        chk("post_reset_handshakes", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);

        for (int v = 0; v < nvec; v++) begin
            if (vecs[v].is_wr) do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].exp_led);
            else               do_read(vecs[v].addr, vecs[v].exp_rdata, vecs[v].exp_led);
        end

        // Response back-pressure: second write must wait until the first response is taken.
        @(negedge clk);
        bready = 1'b0; awaddr = 32'h8; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_sig("bp_first_awready", 0, got);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
        end
        awaddr = 32'h8; wdata = 32'h5A5A5A5A; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("bp_no_awready", {31'd0, awready}, 32'd0);
        end
        bready = 1'b1;
        wait_sig("bp_second_awready", 0, got);
        $display("WRITE back-pressure second accept got=%0d", got);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bp_second_bvalid", {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1;
        chk("bp_second_bvalid_clear", {31'd0, bvalid}, 32'd0);
        do_read(32'h8, 32'h5A5A5A5A, led_of(8'h0F));

        // Same-edge read and write of reg1: read sees the old value.
        @(negedge clk);
        awaddr = 32'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h4; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        wait_sig("same_awready", 0, got);
        chk("same_arready", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_rvalid", {31'd0, rvalid}, 32'd1);
        chk("same_rdata_old", rdata, 32'hDEADBEEF);
        chk("same_bvalid", {31'd0, bvalid}, 32'd1);
        $display("RDWR  same-edge reg1 rdata=%h", rdata);
        @(posedge clk); #1;
        do_read(32'h4, 32'hCAFEF00D, led_of(8'h0F));

        // Asynchronous reset while a response is pending.
        @(negedge clk);
        bready = 1'b0; awaddr = 32'hC; wdata = 32'h11111111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_sig("ar_awready", 0, got);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("ar_bvalid_before", {31'd0, bvalid}, 32'd1);
        chk("ar_led_before", {24'd0, led}, {24'd0, led_of(8'h0F)});
        #1 rst = 1'b1;
        #1;
        chk("ar_bvalid_async", {31'd0, bvalid}, 32'd0);
        chk("ar_led_async", {24'd0, led}, {24'd0, led_of(8'h00)});
        $display("RESET async mid-cycle bvalid=%0d led=%h", bvalid, led);
        @(negedge clk);
        rst = 1'b0; bready = 1'b1;
        for (int r = 0; r < 4; r++) do_read(32'(r * 4), 32'd0, led_of(8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/my_led_axil.md
Name: my_led_axil

Overview:
- AXI4-Lite slave peripheral with four 32-bit software-visible registers.
- The low byte of register 0 drives an 8-bit LED output.
- Sits on the processor's general-purpose AXI interconnect as a simple memory-mapped GPIO-style LED controller.
- Single clock domain; no interrupts.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 32, address bus width; only bits [3:2] are decoded, minimum legal value is 4.

Ports:
- s_axi_aclk  in  1  bus and logic clock, all state on the rising edge.
- s_axi_areset  in  1  reset; one clock, reset is asynchronous and active-high.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address accepted.
- s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  4  byte write enables.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data accepted.
- s_axi_bresp  out  2  write response, always 2'b00 (OKAY).
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  master accepts response.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address accepted.
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response, always 2'b00.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  master accepts read data.
- led  out  8  LED drive, equals reg0[7:0].

Behaviour:
- Register map, decoded on addr[3:2]: 0x0 reg0 (LED), 0x4 reg1, 0x8 reg2, 0xC reg3.
  - reg1–reg3 are scratch registers.
  - Address bits [1:0] and bits above [3] are ignored, so higher addresses alias.
- Reset (async assert, sync-safe deassert):
  - All registers 0.
  - awready, wready, bvalid, arready, rvalid all 0.
  - rdata 0, bresp and rresp 0, led 0.
  - Any in-flight transaction is abandoned.
- Write accept:
  - When awvalid=1, wvalid=1, bvalid=0 and no accept occurred in the previous cycle, assert awready and wready together for exactly one cycle.
  - Address and data are captured on that edge.
  - A single valid without the other is never accepted; it waits.
- Register update occurs on the accept edge. For each byte n with wstrb[n]=1, reg[byte n] is updated from wdata[byte n]. wstrb=0 leaves the register unchanged but still produces a response.
- led reflects the new reg0[7:0] in the cycle after the accept edge.
- Write response:
  - bvalid rises the cycle after accept and holds until bready=1 at a rising edge, then clears.
  - While bvalid=1, no new write is accepted.
- Read accept:
  - When arvalid=1 and rvalid=0, assert arready for one cycle and latch araddr.
  - rvalid rises the next cycle with rdata = selected register and holds stable until rready=1 at a rising edge.
  - No new read is accepted while rvalid=1.
- Read and write channels operate independently.
  - On a same-cycle read and write of the same register, the read returns the pre-write value.
- No error responses; every access returns OKAY.

Optional Feature:
- Macro MY_LED_INVERT_EN.
- When defined: led = ~reg0[7:0] (active-low boards), so led is 8'hFF during reset. Register readback is unaffected.
- When undefined: led = reg0[7:0].

Test Plan:
- Reset held 20 ns, then released -> led=8'h00, all valid/ready outputs 0; a read of 0x0–0xC returns 0.
- Sequential writes of 0x0–0xF to addr 0x0, wstrb=4'hF, awvalid/wvalid together, bready=1:
  - awready and wready pulse together for one cycle.
  - bvalid follows with bresp=00.
  - led steps 0x00→0x0F, each update visible one cycle after accept.
- Write 0x0000AB00 to 0x0 with wstrb=4'b0010 after reg0=0x0000000F -> reg0 reads 0x0000AB0F, led stays 0x0F.
- Write 0xDEADBEEF to 0x4, then 0x12345678 to 0xC, then read both:
  - rdata returns 0xDEADBEEF and 0x12345678, rresp=00.
  - led is unchanged.
- Hold bready=0 after a write -> bvalid stays 1. A second awvalid/wvalid receives no awready until bready=1 completes the first response.
- Assert reset while bvalid=1 and led=0x0F -> bvalid, led and all registers clear immediately, without waiting for a clock edge.
